hps_uart_peer: RTL and testbench
================================

HPS_UART_PEER -- requirements
Module: hps_uart_peer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk_clk cycles per UART bit (min 4).
REQ-002 SHALL have parameter RX_DEPTH, default 8, RX FIFO entries (power of two).
REQ-003 SHALL have parameter CTS_THRESH, default 6, RX FIFO count at or above which the peer deasserts CTS.
REQ-004 SHALL have port clk_clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port uart_rxd  input  1  serial data from HPS uart1_txd, async.
REQ-007 SHALL have port uart_txd  output  1  serial data to HPS uart1_rxd.
REQ-008 SHALL have port uart_rts_n  input  1  HPS uart1_rts, active-low "HPS may receive", async.
REQ-009 SHALL have port uart_cts_n  output  1  to HPS uart1_cts, active-low "peer may receive".
REQ-010 SHALL have port uart_dsr_n  output  1  to HPS uart1_dsr; 0 out of reset.
REQ-011 SHALL have ports uart_dcd_n and uart_ri_n  output  1  each, constant 1.
REQ-012 SHALL have ports tx_data[7:0] input, tx_valid input, tx_ready output  byte stream to transmit.
REQ-013 SHALL have ports rx_data[7:0] output, rx_valid output, rx_ready input  received byte stream.
REQ-014 SHALL have ports rx_overrun and rx_frame_err  output  1  one-cycle error pulses.

Function
REQ-015 SHALL use frame format 8N1: start 0, 8 data bits LSB first, stop 1, each CLKS_PER_BIT cycles.
REQ-016 SHALL pass uart_rxd and uart_rts_n through two-flop synchronizers before any use.
REQ-017 SHALL implement TX FSM IDLE->START->DATA->STOP->IDLE; uart_txd=1 in IDLE.
REQ-018 SHALL assert tx_ready only in TX IDLE with synchronized rts_n=0; transfer on tx_valid&tx_ready.
REQ-019 SHALL drive uart_txd low the cycle after the transfer, as a registered output.
REQ-020 SHALL complete a frame in exactly 10*CLKS_PER_BIT cycles, then hold tx_ready=0 for one IDLE cycle.
REQ-021 SHALL ignore rts_n deassertion mid-frame; it blocks only the next transfer.
REQ-022 SHALL implement RX FSM IDLE->START->DATA->STOP->IDLE, with an additional WAIT_HIGH state.
REQ-023 SHALL leave RX IDLE on a synchronized 1->0 transition of rxd.
REQ-024 SHALL sample rxd at CLKS_PER_BIT/2 into START; a sample of 1 is a glitch and SHALL return the FSM to IDLE with no pulse.
REQ-025 SHALL take each subsequent sample (8 data bits, stop) at CLKS_PER_BIT intervals from the START sample.
REQ-026 SHALL push the byte to the FIFO when the stop sample is 1, then go to IDLE.
REQ-027 SHALL, when the stop sample is 0, discard the byte, pulse rx_frame_err, and hold in WAIT_HIGH until rxd=1, then go to IDLE.
REQ-028 SHALL make the FIFO first-word fall-through: rx_valid=(count!=0), rx_data=head, pop on rx_valid&rx_ready.
REQ-029 SHALL accept a push if count<RX_DEPTH or a pop occurs the same cycle.
REQ-030 SHALL drop a push when FIFO full without a pop, keep contents unchanged, and pulse rx_overrun for one cycle.
REQ-031 SHALL leave count unchanged on a simultaneous push and pop; pointers wrap modulo RX_DEPTH.
REQ-032 SHALL register uart_cts_n = (count >= CTS_THRESH), updating one cycle after the count changes.
REQ-033 SHALL keep the TX and RX paths fully independent (full duplex).

Reset
REQ-034 SHALL, on reset_reset=1 at a clock edge, set both FSMs to IDLE, all counters to 0, and empty the FIFO.
REQ-035 SHALL set reset values: uart_txd=1, uart_cts_n=1, uart_dsr_n=1, tx_ready=0, rx_valid=0, rx_overrun=0, rx_frame_err=0, synchronizer flops=1.
REQ-036 SHALL abort any frame in progress on reset mid-frame with no pulse; uart_txd=1 from the next edge.
REQ-037 SHALL drive uart_cts_n=0 and uart_dsr_n=0 on the first cycle after reset deasserts.

Verification (CLKS_PER_BIT=16)
REQ-038 TX: rts_n=0, send 0xA5 -> uart_txd 0,1,0,1,0,0,1,0,1,1 at 16-cycle bits; tx_ready low 161 cycles.
REQ-039 RX: drive frame 0x3C -> rx_valid rises 2-4 cycles after stop-bit midpoint, rx_data=0x3C; no error pulses.
REQ-040 Flow: rx_ready=0, receive 6 bytes -> uart_cts_n=1 one cycle after 6th push; pop one -> cts_n=0.
REQ-041 Overrun: rx_ready=0, receive 9 bytes -> 8 stored in order, rx_overrun single pulse on the 9th.
REQ-042 Errors: 5-cycle low glitch -> no push, no pulse. Frame with stop=0 -> rx_frame_err pulse, no push, FSM stays out of IDLE until the line goes high.
REQ-043 Gating: rts_n=1 with tx_valid=1 -> tx_ready=0, txd=1. Reset asserted at bit 4 of TX -> txd=1 and FSM IDLE after the edge.

Source files
------------

// File: rtl/hps_uart_peer.sv
// rtl/hps_uart_peer.sv - 8N1 UART peer for the HPS uart1 port with RTS/CTS flow control and an RX FIFO
module hps_uart_peer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int RX_DEPTH     = 8,
    parameter int CTS_THRESH   = 6
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic       uart_rts_n,
    output logic       uart_cts_n,
    output logic       uart_dsr_n,
    output logic       uart_dcd_n,
    output logic       uart_ri_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(RX_DEPTH);
    localparam logic [NW-1:0] CTS_TH    = NW'(CTS_THRESH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    logic rxd_s1, rxd_s2, rxd_s3;
    logic rts_s1, rts_s2;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_hold;

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_push;

    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          pop, full, push_ok;

    assign uart_dcd_n = 1'b1;
    assign uart_ri_n  = 1'b1;

    // rxd_s3 is the previous synchronized sample, used only for falling-edge detection
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
            rts_s1 <= 1'b1;
            rts_s2 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
            rts_s1 <= uart_rts_n;
            rts_s2 <= rts_s1;
        end
    end

    assign tx_ready = (tx_state == TX_IDLE) && !tx_hold && !rts_s2;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_hold  <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    tx_hold  <= 1'b0;
                    uart_txd <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                        uart_txd <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            uart_txd <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_hold  <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // START is entered one cycle after the edge, so its counter starts at 1 to land on mid-bit
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (rxd_s3 && !rxd_s2) begin
                        rx_cnt   <= CW'(1);
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt >= HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rxd_s2) begin
                            rx_push  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            rx_state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxd_s2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid = (count != '0);
    assign rx_data  = fifo_mem[rd_ptr];
    assign pop      = rx_valid && rx_ready;
    assign full     = (count == DEPTH_N);
    assign push_ok  = rx_push && (!full || pop);

    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_overrun <= 1'b0;
            uart_cts_n <= 1'b1;
            uart_dsr_n <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            rx_overrun <= rx_push && full && !pop;
            uart_cts_n <= (count >= CTS_TH);
            uart_dsr_n <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hps_uart_peer.sv
// tb/tb_hps_uart_peer.sv - directed and randomized bench for hps_uart_peer against a byte-level model
module tb_hps_uart_peer;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       uart_rxd;
    logic       uart_txd;
    logic       uart_rts_n;
    logic       uart_cts_n;
    logic       uart_dsr_n;
    logic       uart_dcd_n;
    logic       uart_ri_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       rx_frame_err;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q [$];
    int exp_ovr = 0;

    hps_uart_peer #(.CLKS_PER_BIT(16), .RX_DEPTH(8), .CTS_THRESH(6)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .uart_rts_n(uart_rts_n), .uart_cts_n(uart_cts_n),
        .uart_dsr_n(uart_dsr_n), .uart_dcd_n(uart_dcd_n), .uart_ri_n(uart_ri_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) begin
        if (rx_overrun) ovr_cnt++;
        if (rx_frame_err) fe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    // The line-level picture of a byte: start 0, data LSB first, stop bit
    task automatic tx_send_check(input logic [7:0] b);
        int n, low, wn;
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        wn = 0;
        while (!tx_ready && wn < 200) begin
            cycles(1);
            wn++;
        end
        check("tx_ready_wait", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
        low = 0;
        n = 0;
        while (!tx_ready && n < 400) begin
            if (n % 16 == 8 && n < 160)
                check($sformatf("txd_bit%0d_of_%02h", n / 16, b), uart_txd, frame[n / 16]);
            low++;
            cycles(1);
            n++;
        end
        check("tx_ready_low_cycles", low, 161);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, output int rise_j, output int cts_j);
        logic [9:0] frame;
        logic pv, pc;
        frame  = {stop, b, 1'b0};
        rise_j = -1;
        cts_j  = -1;
        cycles(1);
        for (int i = 0; i < 9; i++) begin
            uart_rxd = frame[i];
            cycles(16);
        end
        uart_rxd = frame[9];
        pv = rx_valid;
        pc = uart_cts_n;
        for (int j = 1; j <= 16; j++) begin
            cycles(1);
            if (rx_valid && !pv && rise_j < 0) rise_j = j;
            if (uart_cts_n && !pc && cts_j < 0) cts_j = j;
            pv = rx_valid;
            pc = uart_cts_n;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < 8) exp_q.push_back(b);
        else exp_ovr++;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, e);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
    endtask

    logic [7:0] b1, b2;
    int rj, cj, rj2, cj2, ovr0, fe0, bad, wn;

    initial begin
        reset_reset = 1'b1;
        uart_rxd    = 1'b1;
        uart_rts_n  = 1'b1;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        rx_ready    = 1'b0;
        cycles(3);
        check("rst_txd", uart_txd, 1);
        check("rst_cts_n", uart_cts_n, 1);
        check("rst_dsr_n", uart_dsr_n, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_pulses", {rx_overrun, rx_frame_err}, 0);
        check("dcd_ri", {uart_dcd_n, uart_ri_n}, 2'b11);
        reset_reset = 1'b0;
        cycles(1);
        check("post_rst_cts_n", uart_cts_n, 0);
        check("post_rst_dsr_n", uart_dsr_n, 0);

        uart_rts_n = 1'b0;
        cycles(4);
        tx_send_check(8'hA5);

        fe0 = fe_cnt;
        ovr0 = ovr_cnt;
        rx_frame(8'h3C, 1'b1, rj, cj);
        model_push(8'h3C);
        check("rx_3c_latency_ok", (rj >= 10 && rj <= 12), 1);
        check("rx_3c_no_err", (fe_cnt - fe0) + (ovr_cnt - ovr0), 0);
        pop_check("rx_3c");

        for (int t = 0; t < 3; t++) begin
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            fork
                tx_send_check(b1);
                rx_frame(b2, 1'b1, rj2, cj2);
            join
            model_push(b2);
            pop_check("duplex_rx");
        end

        for (int t = 0; t < 6; t++) begin
            b1 = 8'($urandom);
            rx_frame(b1, 1'b1, rj, cj);
            model_push(b1);
            if (t == 4) check("cts_n_at_5", uart_cts_n, 0);
        end
        check("cts_n_at_6", uart_cts_n, 1);
        check("cts_rise_timing_ok", (cj >= 11 && cj <= 13), 1);
        pop_check("flow_pop");
        check("cts_n_lags_pop", uart_cts_n, 1);
        cycles(1);
        check("cts_n_after_pop", uart_cts_n, 0);
        while (exp_q.size() > 0) pop_check("flow_drain");
        check("flow_empty", rx_valid, 0);

        ovr0 = ovr_cnt;
        exp_ovr = 0;
        for (int t = 0; t < 9; t++) begin
            b1 = 8'($urandom);
            rx_frame(b1, 1'b1, rj, cj);
            model_push(b1);
        end
        check("overrun_pulses", ovr_cnt - ovr0, exp_ovr);
        while (exp_q.size() > 0) pop_check("ovr_drain");
        check("ovr_empty", rx_valid, 0);

        fe0 = fe_cnt;
        ovr0 = ovr_cnt;
        uart_rxd = 1'b0;
        cycles(5);
        uart_rxd = 1'b1;
        cycles(40);
        check("glitch_no_push", rx_valid, 0);
        check("glitch_no_pulse", (fe_cnt - fe0) + (ovr_cnt - ovr0), 0);

        rx_frame(8'($urandom), 1'b0, rj, cj);
        cycles(40);
        check("frame_err_pulse", fe_cnt - fe0, 1);
        check("frame_err_no_push", rx_valid, 0);
        uart_rxd = 1'b1;
        cycles(20);
        b1 = 8'($urandom);
        rx_frame(b1, 1'b1, rj, cj);
        model_push(b1);
        check("recover_no_err", fe_cnt - fe0, 1);
        pop_check("recover");

        uart_rts_n = 1'b1;
        cycles(4);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_ready !== 1'b0 || uart_txd !== 1'b1) bad++;
            cycles(1);
        end
        tx_valid = 1'b0;
        check("rts_gating_violations", bad, 0);

        uart_rts_n = 1'b0;
        rx_frame(8'h5A, 1'b1, rj, cj);
        check("pre_reset_fifo", rx_valid, 1);
        wn = 0;
        while (!tx_ready && wn < 20) begin cycles(1); wn++; end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
        cycles(4 * 16 + 8);
        check("mid_tx_txd_low", uart_txd, 0);
        fe0 = fe_cnt;
        reset_reset = 1'b1;
        cycles(1);
        check("reset_txd_high", uart_txd, 1);
        check("reset_tx_ready", tx_ready, 0);
        check("reset_fifo_empty", rx_valid, 0);
        reset_reset = 1'b0;
        wn = 0;
        while (!tx_ready && wn < 10) begin
            if (uart_txd !== 1'b1) bad++;
            cycles(1);
            wn++;
        end
        check("reset_tx_idle_ready", tx_ready, 1);
        check("reset_txd_stays_high", bad, 0);
        check("reset_no_pulse", fe_cnt - fe0, 0);
        exp_q.delete();
        b1 = 8'($urandom);
        tx_send_check(b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
